// File: rtl/cstream_pkg.sv
// cstream_pkg: shared FSM state type and parameter defaults for the instruction-issue stage
package cstream_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_FREE} state_t;
  localparam int ADDR_W_DEF      = 8;
  localparam int INST_W_DEF      = 32;
  localparam int BURST_LEN_DEF   = 4;
  localparam int FREE_W_DEF      = 2;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/cdrive_toggle_sync.sv
// cdrive_toggle_sync: turns each rising edge of async i_drive into a one-cycle clk-domain event
// Ports: clk, rst (raw async active-low, clears the toggle), i_rst_sync (release-synchronized
// active-low reset for the clk-domain flops), i_drive (async pulse), o_drive_evt (one-cycle event).
module cdrive_toggle_sync import cstream_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rst_sync,
  input  logic i_drive,
  output logic o_drive_evt
);
  logic                   tgl_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  always_ff @(posedge i_drive or negedge rst) begin
    if (!rst) tgl_q <= 1'b0;
    else      tgl_q <= ~tgl_q;
  end
  always_ff @(posedge clk or negedge i_rst_sync) begin
    if (!i_rst_sync) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_q};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign o_drive_evt = sync_q[SYNC_STAGES-1] ^ prev_q;
endmodule

// File: rtl/cstream_inst_issue.sv
// cstream_inst_issue: per drive event, fetch BURST_LEN instructions at the PC and stream them out
// Ports: clk, rst (async active-low); i_drive/o_free to the merge; i_pc_load/i_pc_value PC load;
// o_imem_req/o_imem_addr/i_imem_gnt/i_imem_rvalid/i_imem_rdata memory read port;
// o_inst_valid/o_inst_data/i_inst_ready instruction stream; o_busy, o_err_overrun status.
module cstream_inst_issue import cstream_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INST_W      = INST_W_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int FREE_W      = FREE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive,
  output logic              o_free,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_value,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst_data,
  input  logic              i_inst_ready,
  output logic              o_busy,
  output logic              o_err_overrun
);
  localparam int FC_W = $clog2(FREE_W + 1);
  logic [1:0]        rst_sync_q;
  logic              rst_n_s;
  logic              drive_evt;
  state_t            state_q;
  logic [7:0]        beat_cnt_q;
  logic [FC_W-1:0]   free_cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] data_q;
  logic              req_q, valid_q, free_q, busy_q, err_q;
  // Assertion is immediate; release is delayed two clk edges to avoid recovery hazards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];
  cdrive_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_rst_sync  (rst_n_s),
    .i_drive     (i_drive),
    .o_drive_evt (drive_evt)
  );
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      free_cnt_q <= '0;
      pc_q       <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      free_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // A drive outside IDLE is dropped; only the sticky flag records it.
      if (drive_evt && state_q != S_IDLE) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (i_pc_load) pc_q <= i_pc_value;
          if (drive_evt) begin
            state_q    <= S_REQ;
            beat_cnt_q <= '0;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_REQ: if (i_imem_gnt) begin
          state_q <= S_WAIT;
          req_q   <= 1'b0;
        end
        S_WAIT: if (i_imem_rvalid) begin
          state_q <= S_ISSUE;
          data_q  <= i_imem_rdata;
          valid_q <= 1'b1;
          pc_q    <= pc_q + ADDR_W'(1);
        end
        S_ISSUE: if (i_inst_ready) begin
          valid_q    <= 1'b0;
          beat_cnt_q <= beat_cnt_q + 8'd1;
          if (beat_cnt_q == 8'(BURST_LEN - 1)) begin
            state_q    <= S_FREE;
            free_q     <= 1'b1;
            free_cnt_q <= '0;
          end else begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_FREE: if (free_cnt_q == FC_W'(FREE_W - 1)) begin
          state_q <= S_IDLE;
          free_q  <= 1'b0;
          busy_q  <= 1'b0;
        end else free_cnt_q <= free_cnt_q + FC_W'(1);
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign o_free        = free_q;
  assign o_imem_req    = req_q;
  assign o_imem_addr   = pc_q;
  assign o_inst_valid  = valid_q;
  assign o_inst_data   = data_q;
  assign o_busy        = busy_q;
  assign o_err_overrun = err_q;
endmodule

// File: doc/cstream_inst_issue.md
# cstream_inst_issue

Clocked instruction-issue stage directly downstream of the four-way stream-instruction mutex merge. Each merged drive event fetches a burst of `BURST_LEN` instructions from the instruction memory at a free-running program counter and streams them out on a valid/ready port. When the last instruction is accepted, it returns a `free` pulse to the merge's `i_freeNext`. It is the bridge from the click-based control fabric into the synchronous datapath.

## Interface
- `ADDR_W`, 8: instruction address width; PC wraps modulo 2^ADDR_W.
- `INST_W`, 32: instruction width.
- `BURST_LEN`, 4: instructions issued per drive event, range 1..255.
- `FREE_W`, 2: `o_free` pulse width in clk cycles, ≥1.
- `SYNC_STAGES`, 2: synchronizer depth, ≥2.
- `clk`  in  1  single clock for the stage.
- `rst`  in  1  reset, asynchronous, active-low. Asserting (0) resets all state at once. Release is synchronized internally.
- `i_drive`  in  1  drive pulse from the merge's `o_driveNext`; asynchronous to `clk`.
- `o_free`  out  1  free pulse to the merge's `i_freeNext`.
- `i_pc_load`  in  1  loads `i_pc_value` into the PC; honoured only in IDLE.
- `i_pc_value`  in  ADDR_W  PC load value.
- `o_imem_req`  out  1  instruction memory read request.
- `o_imem_addr`  out  ADDR_W  read address.
- `i_imem_gnt`  in  1  request accepted.
- `i_imem_rvalid`  in  1  read data valid, one per granted request, in order.
- `i_imem_rdata`  in  INST_W  read data.
- `o_inst_valid`  out  1  instruction stream valid.
- `o_inst_data`  out  INST_W  instruction.
- `i_inst_ready`  in  1  downstream accepts.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_err_overrun`  out  1  sticky; a drive event arrived while not IDLE. Cleared only by reset.

## Operation
**Drive capture**
- A rising edge of `i_drive` toggles a capture flop clocked by `i_drive` itself. This flop is reset by `rst`.
- The toggle passes through a `SYNC_STAGES` synchronizer. Each change of the synchronized toggle is one drive event.

**FSM**
- IDLE: on a drive event, latch `beat_cnt = 0` and go to REQ. `i_pc_load` writes the PC in IDLE only.
- REQ: `o_imem_req = 1`, `o_imem_addr = pc`. On `i_imem_gnt`, go to WAIT.
- WAIT: on `i_imem_rvalid`, capture `i_imem_rdata` into the output register and go to ISSUE. `pc <= pc + 1`, wrapping at 2^ADDR_W.
- ISSUE: `o_inst_valid = 1`, data held stable until `i_inst_ready`. On handshake, increment `beat_cnt`:
  - if `beat_cnt == BURST_LEN-1`, go to FREE;
  - otherwise go to REQ.
- FREE: `o_free = 1` for exactly `FREE_W` cycles, counted by `free_cnt`, then go to IDLE.

**Rules**
- Only one read is outstanding; `rvalid` without a prior grant is ignored.
- A drive event while not IDLE sets `o_err_overrun`. The event is dropped, and the current burst continues unaffected.
- `i_pc_load` outside IDLE is ignored.
- `o_free` is driven from a flop; it is glitch-free.

## Timing
- Reset values: `o_free=0`, `o_imem_req=0`, `o_imem_addr=0`, `o_inst_valid=0`, `o_inst_data=0`, `o_busy=0`, `o_err_overrun=0`, `pc=0`, state IDLE, toggle flops 0.
- Reset mid-burst returns to IDLE immediately. No `o_free` is issued, and in-flight memory data is discarded.
- Drive-to-request latency: `SYNC_STAGES+1` clk edges after the first clk edge following the `i_drive` rise, i.e. `o_imem_req` on cycle 3 with defaults.
- Per-beat minimum latency with `gnt` and `rvalid` in the cycle after each request and `ready` held high: REQ 1 + WAIT 1 + ISSUE 1 = 3 cycles/beat.
- Last accept → `o_free` rises next cycle, held `FREE_W` cycles.
- `i_drive` pulses must be ≥ one min-pulse-width of the capture flop. Consecutive drives must be spaced > `SYNC_STAGES+1` clk periods; the merge's free-before-drive protocol guarantees this.

## Structure
- Package `cstream_pkg`: FSM state enum (IDLE, REQ, WAIT, ISSUE, FREE) and parameter default constants.
- Sub-module `cdrive_toggle_sync`: the `i_drive`-clocked toggle flop, the `SYNC_STAGES` synchronizer, and the change detector. Output is a one-cycle `drive_evt` in the `clk` domain.

## Test plan
- **Single burst.** Reset, load PC=0x10, one `i_drive` pulse, memory returns 0xA0..0xA3 with `gnt`/`rvalid` next cycle, ready=1.
  - Expect four beats 0xA0..0xA3 at addresses 0x10..0x13.
  - Expect `o_free` high 2 cycles, then PC=0x14.
- **Wrap.** PC=0xFE, drive.
  - Expect addresses 0xFE, 0xFF, 0x00, 0x01; PC ends at 0x02.
- **Backpressure.** Hold `ready=0` for 5 cycles on beat 2.
  - Expect `o_inst_data` stable and `valid` held.
  - Expect no extra memory request; burst completes normally.
- **Overrun.** Second `i_drive` during beat 1.
  - Expect `o_err_overrun=1` (sticky) and still exactly 4 beats and one free pulse.
  - A following drive after free is served normally.
- **Reset mid-burst.** Assert `rst=0` during WAIT.
  - Expect all outputs at reset values while low, no `o_free`, and IDLE after release.
- **PC load gating.** Pulse `i_pc_load` with value 0x40 while busy.
  - Expect it ignored; the same load in IDLE takes effect on the next burst.
